// File: rtl/hazard_forward_pipe_pkg.sv
// pipe_pkg: shared definitions for hazard_forward_pipe.
//   - default parameter constants for the pipeline and its forwarding muxes
//   - stage_ctrl_t: per-stage control flags of a stage entry
//   - sel_w(): width of one per-source forwarding-select field
package pipe_pkg;

  localparam int unsigned DATA_W_DEF     = 32;
  localparam int unsigned REG_AW_DEF     = 5;
  localparam int unsigned NUM_SRC_DEF    = 2;
  localparam int unsigned STAGES_DEF     = 3;
  localparam int unsigned LOAD_STAGE_DEF = 2;

  // Control part of a stage entry; dst/data live beside it in arrays sized
  // by the instantiating module's parameters.
  typedef struct packed {
    logic valid;
    logic reg_write;
    logic is_load;
    logic rdy;
  } stage_ctrl_t;

  function automatic int unsigned sel_w(input int unsigned stages);
    return (stages < 2) ? 32'd1 : 32'($clog2(stages));
  endfunction

endpackage

// File: rtl/hazard_forward_pipe_fwd_mux.sv
// operand_forward_mux: priority forwarding select for one source operand.
//   src_addr/src_data : source register number and its captured RF data
//   prod              : producer-candidate flag per stage 1..DEPTH (bit k = stage k+1)
//   prod_dst/prod_data: destination and data of those stages
//   op_data/sel       : chosen operand and stage index (0 = register file)
module operand_forward_mux
  import pipe_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned REG_AW = REG_AW_DEF,
  parameter int unsigned DEPTH  = STAGES_DEF - 1,
  parameter int unsigned SEL_W  = 2
) (
  input  logic [REG_AW-1:0]       src_addr,
  input  logic [DATA_W-1:0]       src_data,
  input  logic [DEPTH-1:0]        prod,
  input  logic [DEPTH*REG_AW-1:0] prod_dst,
  input  logic [DEPTH*DATA_W-1:0] prod_data,
  output logic [DATA_W-1:0]       op_data,
  output logic [SEL_W-1:0]        sel
);

  // Scan from the youngest stage; the first hit wins. r0 never forwards.
  always_comb begin : pick
    logic found;
    found   = 1'b0;
    op_data = src_data;
    sel     = '0;
    for (int unsigned k = 0; k < DEPTH; k++) begin
      if (!found && prod[k] && (src_addr != '0) &&
          (prod_dst[k*REG_AW +: REG_AW] == src_addr)) begin
        found   = 1'b1;
        op_data = prod_data[k*DATA_W +: DATA_W];
        sel     = SEL_W'(k + 1);
      end
    end
  end

endmodule

// File: rtl/hazard_forward_pipe.sv
// hazard_forward_pipe: tracks STAGES pipeline stages after ID (0 = EX,
// STAGES-1 = WB), stalls ID on load-use hazards and forwards results to
// the stage-0 operands.
//   clk, reset            : clock, synchronous active-high reset
//   id_*                  : instruction currently in ID and its RF read data
//   flush                 : kill the ID and stage-0 instructions
//   ex_result, mem_rdata  : stage-0 result, load data for LOAD_STAGE entry
//   stall                 : hold PC and IF/ID
//   ex_valid/ex_dst_addr  : stage-0 status
//   ex_op_data, fwd_sel   : forwarded stage-0 operands and their source stage
//   wb_we/wb_addr/wb_data : register-file write port from the last stage
module hazard_forward_pipe
  import pipe_pkg::*;
#(
  parameter int unsigned DATA_W     = DATA_W_DEF,
  parameter int unsigned REG_AW     = REG_AW_DEF,
  parameter int unsigned NUM_SRC    = NUM_SRC_DEF,
  parameter int unsigned STAGES     = STAGES_DEF,
  parameter int unsigned LOAD_STAGE = LOAD_STAGE_DEF
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              id_valid,
  input  logic [NUM_SRC*REG_AW-1:0]         id_src_addr,
  input  logic [NUM_SRC*DATA_W-1:0]         id_src_data,
  input  logic [REG_AW-1:0]                 id_dst_addr,
  input  logic                              id_reg_write,
  input  logic                              id_is_load,
  input  logic                              flush,
  input  logic [DATA_W-1:0]                 ex_result,
  input  logic [DATA_W-1:0]                 mem_rdata,
  output logic                              stall,
  output logic                              ex_valid,
  output logic [REG_AW-1:0]                 ex_dst_addr,
  output logic [NUM_SRC*DATA_W-1:0]         ex_op_data,
  output logic [NUM_SRC*sel_w(STAGES)-1:0]  fwd_sel,
  output logic                              wb_we,
  output logic [REG_AW-1:0]                 wb_addr,
  output logic [DATA_W-1:0]                 wb_data
);

  localparam int unsigned SEL_W = sel_w(STAGES);
  localparam int unsigned DEPTH = STAGES - 1;

  stage_ctrl_t       flg      [STAGES];
  logic [REG_AW-1:0] dst      [STAGES];
  logic [DATA_W-1:0] data     [STAGES];
  logic [REG_AW-1:0] src_addr [NUM_SRC];
  logic [DATA_W-1:0] src_data [NUM_SRC];

  stage_ctrl_t       nxt_flg      [STAGES];
  logic [REG_AW-1:0] nxt_dst      [STAGES];
  logic [DATA_W-1:0] nxt_data     [STAGES];
  logic [REG_AW-1:0] nxt_src_addr [NUM_SRC];
  logic [DATA_W-1:0] nxt_src_data [NUM_SRC];

  logic stall_hit;

  // A load still short of LOAD_STAGE-1 cannot supply data in time for an
  // ID consumer that would enter stage 0 next cycle.
  always_comb begin
    stall_hit = 1'b0;
    for (int unsigned i = 0; i < NUM_SRC; i++) begin
      for (int unsigned s = 0; s + 1 < LOAD_STAGE; s++) begin
        if ((id_src_addr[i*REG_AW +: REG_AW] != '0) && flg[s].valid &&
            flg[s].reg_write && flg[s].is_load && !flg[s].rdy &&
            (dst[s] == id_src_addr[i*REG_AW +: REG_AW]))
          stall_hit = 1'b1;
      end
    end
  end

  assign stall = id_valid & ~flush & stall_hit;

  always_comb begin
    for (int unsigned i = 0; i < NUM_SRC; i++) begin
      nxt_src_addr[i] = '0;
      nxt_src_data[i] = '0;
    end
    nxt_flg[0]  = '0;
    nxt_dst[0]  = '0;
    nxt_data[0] = '0;
    if (id_valid && !flush && !stall_hit) begin
      nxt_flg[0] = '{valid: 1'b1, reg_write: id_reg_write,
                     is_load: id_is_load, rdy: 1'b0};
      nxt_dst[0] = id_dst_addr;
      for (int unsigned i = 0; i < NUM_SRC; i++) begin
        nxt_src_addr[i] = id_src_addr[i*REG_AW +: REG_AW];
        nxt_src_data[i] = id_src_data[i*DATA_W +: DATA_W];
      end
    end
    for (int unsigned s = 1; s < STAGES; s++) begin
      nxt_flg[s]  = flg[s-1];
      nxt_dst[s]  = dst[s-1];
      nxt_data[s] = data[s-1];
      if (s == 1) begin
        nxt_data[s]    = ex_result;
        nxt_flg[s].rdy = ~flg[0].is_load;
      end
      if ((s == LOAD_STAGE) && flg[s-1].is_load) begin
        nxt_data[s]    = mem_rdata;
        nxt_flg[s].rdy = 1'b1;
      end
    end
    if (flush) begin
      nxt_flg[1]  = '0;
      nxt_dst[1]  = '0;
      nxt_data[1] = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned s = 0; s < STAGES; s++) begin
        flg[s]  <= '0;
        dst[s]  <= '0;
        data[s] <= '0;
      end
      for (int unsigned i = 0; i < NUM_SRC; i++) begin
        src_addr[i] <= '0;
        src_data[i] <= '0;
      end
    end else begin
      for (int unsigned s = 0; s < STAGES; s++) begin
        flg[s]  <= nxt_flg[s];
        dst[s]  <= nxt_dst[s];
        data[s] <= nxt_data[s];
      end
      for (int unsigned i = 0; i < NUM_SRC; i++) begin
        src_addr[i] <= nxt_src_addr[i];
        src_data[i] <= nxt_src_data[i];
      end
    end
  end

  logic [DEPTH-1:0]        prod;
  logic [DEPTH*REG_AW-1:0] prod_dst;
  logic [DEPTH*DATA_W-1:0] prod_data;

  always_comb begin
    prod      = '0;
    prod_dst  = '0;
    prod_data = '0;
    for (int unsigned k = 0; k < DEPTH; k++) begin
      prod[k]                       = flg[k+1].valid & flg[k+1].reg_write;
      prod_dst[k*REG_AW +: REG_AW]  = dst[k+1];
      prod_data[k*DATA_W +: DATA_W] = data[k+1];
    end
  end

  for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
    operand_forward_mux #(
      .DATA_W (DATA_W),
      .REG_AW (REG_AW),
      .DEPTH  (DEPTH),
      .SEL_W  (SEL_W)
    ) u_mux (
      .src_addr  (src_addr[i]),
      .src_data  (src_data[i]),
      .prod      (prod),
      .prod_dst  (prod_dst),
      .prod_data (prod_data),
      .op_data   (ex_op_data[i*DATA_W +: DATA_W]),
      .sel       (fwd_sel[i*SEL_W +: SEL_W])
    );
  end

  assign ex_valid    = flg[0].valid;
  assign ex_dst_addr = dst[0];
  assign wb_we       = flg[STAGES-1].valid & flg[STAGES-1].reg_write &
                       (dst[STAGES-1] != '0);
  assign wb_addr     = dst[STAGES-1];
  assign wb_data     = data[STAGES-1];

endmodule
